// File: rtl/alu_writeback_if.sv
// ALU-to-writeback handshake bundle: result, flags and destination with a
// valid/ready transfer.
interface alu_writeback_if #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   out_alu;
    logic                  z_a_flag;
    logic                  z_b_flag;
    logic                  a_bigger_flag;
    logic                  b_bigger_flag;
    logic                  eq_flag;
    logic                  wide;
    logic [RA_W-1:0]       dest;

    modport master (
        output in_valid, out_alu, z_a_flag, z_b_flag, a_bigger_flag,
               b_bigger_flag, eq_flag, wide, dest,
        input  in_ready
    );

    modport slave (
        input  in_valid, out_alu, z_a_flag, z_b_flag, a_bigger_flag,
               b_bigger_flag, eq_flag, wide, dest,
        output in_ready
    );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures a 2*DATA_W result and flags, writes it to the
// register file as one (narrow) or two (wide, lo then hi) beats, latches status.
module alu_writeback #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_writeback_if.slave       alu,
    output logic                 rf_we,
    output logic [RA_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [5:0]           status,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [2*DATA_W-1:0]   res_q;
    logic [RA_W-1:0]       dest_q;
    logic                  wide_q;
    logic                  accept;
    logic                  hi_nz;

    // Ready on the last beat of an op so a new one can issue without a bubble.
    assign alu.in_ready = (state != WR_LO) || !wide_q;
    assign accept       = alu.in_valid && alu.in_ready;
    assign hi_nz        = (alu.out_alu[2*DATA_W-1:DATA_W] != '0) && !alu.wide;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            res_q  <= '0;
            dest_q <= '0;
            wide_q <= 1'b0;
            status <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                res_q  <= alu.out_alu;
                dest_q <= alu.dest;
                wide_q <= alu.wide;
                status <= {hi_nz, alu.eq_flag, alu.b_bigger_flag,
                           alu.a_bigger_flag, alu.z_b_flag, alu.z_a_flag};
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            WR_LO: begin
                rf_we     = 1'b1;
                rf_waddr  = dest_q;
                rf_wdata  = res_q[DATA_W-1:0];
                state_nxt = wide_q ? WR_HI : IDLE;
            end
            WR_HI: begin
                rf_we     = 1'b1;
                // Address wraps modulo the register count.
                rf_waddr  = dest_q + RA_W'(1);
                rf_wdata  = res_q[2*DATA_W-1:DATA_W];
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (accept)
            state_nxt = WR_LO;
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: reset, narrow/wide writes, wrap,
// truncation, back-to-back issue, backpressure and reset mid-op.
module tb_alu_writeback;
    localparam int DATA_W = 16;
    localparam int RA_W   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic              rf_we;
    logic [RA_W-1:0]   rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [5:0]        status;
    logic              busy;

    int tests = 0;
    int fails = 0;

    alu_writeback_if #(.DATA_W(DATA_W), .RA_W(RA_W)) alu ();

    alu_writeback #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu      (alu.slave),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .status   (status),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // flags = {eq, b_bigger, a_bigger, z_b, z_a}
    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] flags,
                         input logic w, input logic [2:0] d);
        alu.in_valid      = v;
        alu.out_alu       = res;
        alu.eq_flag       = flags[4];
        alu.b_bigger_flag = flags[3];
        alu.a_bigger_flag = flags[2];
        alu.z_b_flag      = flags[1];
        alu.z_a_flag      = flags[0];
        alu.wide          = w;
        alu.dest          = d;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, status, busy, alu.in_ready} !== {1'b0, 3'd0, 16'h0, 6'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset: we/addr/data/status/busy/rdy got %b/%0d/%h/%b/%b/%b want 0/0/0000/000000/0/1",
                     rf_we, rf_waddr, rf_wdata, status, busy, alu.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_narrow();
        @(negedge clk);
        drive(1'b1, 32'h0000_0005, 5'b00100, 1'b0, 3'd2);
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, status, busy} !== {1'b1, 3'd2, 16'h0005, 6'b000100, 1'b1}) begin
            fails++;
            $display("FAIL narrow_write: we/addr/data/status/busy got %b/%0d/%h/%b/%b want 1/2/0005/000100/1",
                     rf_we, rf_waddr, rf_wdata, status, busy);
        end
        alu.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({rf_we, busy, status} !== {1'b0, 1'b0, 6'b000100}) begin
            fails++;
            $display("FAIL narrow_idle: we/busy/status got %b/%b/%b want 0/0/000100", rf_we, busy, status);
        end
    endtask

    task automatic test_wide_wrap();
        drive(1'b1, 32'h0001_0004, 5'b00000, 1'b1, 3'd7);
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, alu.in_ready, status} !== {1'b1, 3'd7, 16'h0004, 1'b0, 6'b000000}) begin
            fails++;
            $display("FAIL wide_lo: we/addr/data/rdy/status got %b/%0d/%h/%b/%b want 1/7/0004/0/000000",
                     rf_we, rf_waddr, rf_wdata, alu.in_ready, status);
        end
        alu.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, alu.in_ready} !== {1'b1, 3'd0, 16'h0001, 1'b1}) begin
            fails++;
            $display("FAIL wide_hi_wrap: we/addr/data/rdy got %b/%0d/%h/%b want 1/0/0001/1",
                     rf_we, rf_waddr, rf_wdata, alu.in_ready);
        end
        @(negedge clk);
        tests++;
        if ({rf_we, busy} !== 2'b00) begin
            fails++;
            $display("FAIL wide_idle: we/busy got %b/%b want 0/0", rf_we, busy);
        end
    endtask

    task automatic test_truncation();
        drive(1'b1, 32'h0003_FFFF, 5'b10000, 1'b0, 3'd5);
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, status} !== {1'b1, 3'd5, 16'hFFFF, 6'b110000}) begin
            fails++;
            $display("FAIL truncation: we/addr/data/status got %b/%0d/%h/%b want 1/5/ffff/110000",
                     rf_we, rf_waddr, rf_wdata, status);
        end
        alu.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL truncation_single: we got %b want 0", rf_we);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h0000_0100, 5'b00000, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({rf_we, rf_waddr, rf_wdata, alu.in_ready} !== {1'b1, 3'(i), 16'(16'h0100 + i), 1'b1}) begin
                fails++;
                $display("FAIL b2b_%0d: we/addr/data/rdy got %b/%0d/%h/%b want 1/%0d/%h/1",
                         i, rf_we, rf_waddr, rf_wdata, alu.in_ready, i, 16'(16'h0100 + i));
            end
            if (i < 3) drive(1'b1, 32'h0000_0100 + 32'(i + 1), 5'b00000, 1'b0, 3'(i + 1));
            else       alu.in_valid = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: we got %b want 0", rf_we);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'hBEEF_1234, 5'b00001, 1'b1, 3'd4);
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, alu.in_ready, status} !== {1'b1, 3'd4, 16'h1234, 1'b0, 6'b000001}) begin
            fails++;
            $display("FAIL bp_lo: we/addr/data/rdy/status got %b/%0d/%h/%b/%b want 1/4/1234/0/000001",
                     rf_we, rf_waddr, rf_wdata, alu.in_ready, status);
        end
        drive(1'b1, 32'h0000_0055, 5'b01000, 1'b0, 3'd1);
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, alu.in_ready, status} !== {1'b1, 3'd5, 16'hBEEF, 1'b1, 6'b000001}) begin
            fails++;
            $display("FAIL bp_hi: we/addr/data/rdy/status got %b/%0d/%h/%b/%b want 1/5/beef/1/000001",
                     rf_we, rf_waddr, rf_wdata, alu.in_ready, status);
        end
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata, status} !== {1'b1, 3'd1, 16'h0055, 6'b001000}) begin
            fails++;
            $display("FAIL bp_narrow: we/addr/data/status got %b/%0d/%h/%b want 1/1/0055/001000",
                     rf_we, rf_waddr, rf_wdata, status);
        end
        alu.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (rf_we !== 1'b0) begin
            fails++;
            $display("FAIL bp_end: we got %b want 0", rf_we);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0002_0003, 5'b10000, 1'b1, 3'd3);
        @(negedge clk);
        tests++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h0003}) begin
            fails++;
            $display("FAIL rstmid_lo: we/addr/data got %b/%0d/%h want 1/3/0003", rf_we, rf_waddr, rf_wdata);
        end
        alu.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if ({rf_we, status, alu.in_ready, busy} !== {1'b0, 6'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rstmid_async: we/status/rdy/busy got %b/%b/%b/%b want 0/000000/1/0",
                     rf_we, status, alu.in_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            tests++;
            if ({rf_we, status, alu.in_ready} !== {1'b0, 6'd0, 1'b1}) begin
                fails++;
                $display("FAIL rstmid_%0d: we/status/rdy got %b/%b/%b want 0/000000/1",
                         i, rf_we, status, alu.in_ready);
            end
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, 5'b00000, 1'b0, 3'd0);
        test_reset();
        test_narrow();
        test_wide_wrap();
        test_truncation();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the ALU: captures the 32-bit ALU result and its five compare/zero flags through a valid/ready handshake.
- Writes the result into the 16-bit register file: one write for narrow ops, two consecutive writes for wide ops (low half, then high half).
- Latches the ALU flags, plus a high-half-nonzero indicator, into a status register for branch logic.

Parameters:
- DATA_W, 16, register file word width; the ALU result is 2*DATA_W.
- RA_W, 3, register address width; 8 registers.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result and flags valid this cycle.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
- out_alu  in  2*DATA_W  ALU result.
- z_a_flag, z_b_flag, a_bigger_flag, b_bigger_flag, eq_flag  in  1 each  ALU flags.
- wide  in  1  1 = write both halves; 0 = write low half only.
- dest  in  RA_W  destination register for the low half.
- rf_we  out  1  register file write enable.
- rf_waddr  out  RA_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- status  out  6  {hi_nz, eq, b_bigger, a_bigger, z_b, z_a}.
- busy  out  1  asserted in any state except IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; rf_we=0; rf_waddr=0; rf_wdata=0; status=0; busy=0; internal capture registers cleared. in_ready=1 after reset.
- Reset mid-operation: any pending high-half write is dropped, with no partial write after rst deasserts.
- FSM states:
  - IDLE: rf_we=0.
  - WR_LO: rf_we=1, rf_waddr=dest_q, rf_wdata=res_q[DATA_W-1:0].
  - WR_HI: rf_we=1, rf_waddr=dest_q+1 (mod 2^RA_W, so 7 wraps to 0), rf_wdata=res_q[2*DATA_W-1:DATA_W].
- in_ready is combinational: 1 in IDLE; 1 in WR_LO when wide_q=0; 1 in WR_HI; 0 in WR_LO when wide_q=1.
- Accept (in_valid && in_ready at an edge):
  - Captures out_alu, dest and wide into res_q, dest_q, wide_q.
  - Updates status in the same edge: flags copied; hi_nz = (out_alu[31:16]!=0) && !wide.
  - Next state is WR_LO.
- Transitions without accept:
  - WR_LO -> WR_HI if wide_q, else IDLE.
  - WR_HI -> IDLE.
- Transitions with accept:
  - Acceptance in a last beat (WR_LO narrow, or WR_HI) goes straight to WR_LO.
  - This gives back-to-back narrow ops at 1 op/cycle and wide ops at 1 op per 2 cycles.
- Latency: the low-half write appears in the cycle after accept; the high-half write in the cycle after that.
- Write outputs are registered-state decoded: rf_waddr and rf_wdata depend only on state and capture registers, never on current inputs.
- status holds its value between accepts and is not cleared on IDLE.
- in_valid is ignored while in_ready=0; the upstream stage must hold its data until accepted.
- Inputs are not checked for X/Z; behaviour with an undriven opcode upstream is undefined but must not corrupt state while in_valid=0.

Test Plan:
- Reset mid-op: wide accept, then rst asserted during WR_LO and released two cycles later -> rf_we=0 throughout, status=0, in_ready=1, no WR_HI write.
- Narrow single op: out_alu=32'h0000_0005, dest=2, wide=0, flags a_bigger=1 -> next cycle rf_we=1, rf_waddr=2, rf_wdata=16'h0005; status=6'b000100; then IDLE, busy=0.
- Wide op with wrap: out_alu=32'h0001_0004, dest=7, wide=1 -> cycle+1: addr 7, data 16'h0004; cycle+2: addr 0, data 16'h0001; in_ready=0 during cycle+1.
- Narrow truncation: out_alu=32'h0003_FFFF, wide=0, eq=1 -> single write 16'hFFFF; status=6'b110000.
- Back-to-back narrow: in_valid held high with 4 ops on dest 0..3 -> 4 consecutive rf_we cycles with matching addr/data; in_ready stays 1.
- Backpressure: wide op followed immediately by a narrow op -> narrow op held while in_ready=0, then accepted in WR_HI; writes appear in the order lo, hi, narrow with no gaps.
